// File: rtl/router_iport_param_if.sv
// Router input port bus bundle.
// Groups the serial frame input, the arbiter request/grant pair and the
// deserialised word/status outputs of one router input port.
//   slave  modport : used by router_iport_param (samples i_*, drives o_*)
//   master modport : used by whatever feeds the port (drives i_*, samples o_*)
// Handshake: o_req is a level request that stays high from the cycle after
// the last address bit until the packet ends, drops or aborts; i_gnt is only
// looked at while the port is waiting in REQ, and one sampled i_gnt=1 moves
// the port to payload reception. o_wvalid/o_eop/o_drop/o_err are
// single-cycle pulses with no back-pressure.
// o_state_dbg exposes the port FSM state encoding for observation.
interface router_iport_param_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  localparam int WB_W = $clog2(DATA_W + 1);

  logic              i_frame;
  logic              i_data;
  logic              i_gnt;
  logic [ADDR_W-1:0] o_dst_addr;
  logic              o_req;
  logic [DATA_W-1:0] o_wdata;
  logic              o_wvalid;
  logic [WB_W-1:0]   o_wbits;
  logic              o_eop;
  logic              o_drop;
  logic              o_err;
  logic [2:0]        o_state_dbg;

  modport slave (
    input  i_frame, i_data, i_gnt,
    output o_dst_addr, o_req, o_wdata, o_wvalid, o_wbits,
           o_eop, o_drop, o_err, o_state_dbg
  );

  modport master (
    output i_frame, i_data, i_gnt,
    input  o_dst_addr, o_req, o_wdata, o_wvalid, o_wbits,
           o_eop, o_drop, o_err, o_state_dbg
  );
endinterface

// File: rtl/router_iport_param.sv
// Router input port: receives a serial frame (destination address LSB first,
// then payload LSB first), requests the crossbar, and once granted
// deserialises the payload into DATA_W-bit words. A trailing partial word is
// flushed with its bit count together with the end-of-packet pulse.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : router_iport_param_if.slave (frame/data in, req/gnt,
//           word/status outputs, FSM state for observation)
module router_iport_param #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  router_iport_param_if.slave bus
);
  localparam int AC_W    = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int BC_W    = $clog2(DATA_W);
  localparam int WB_W    = $clog2(DATA_W + 1);
  localparam int WC_W    = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam int TO_LAST = (GNT_TIMEOUT > 0) ? GNT_TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {IDLE, ADDR, REQ, DATA, DROP} state_e;

  state_e            state_q, state_d;
  logic [AC_W-1:0]   acnt_q, acnt_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WB_W-1:0]   wbits_q, wbits_d;
  logic              req_q, req_d;
  logic              wvalid_q, wvalid_d;
  logic              eop_q, eop_d;
  logic              drop_q, drop_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acnt_q   <= '0;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      dst_q    <= '0;
      wdata_q  <= '0;
      wbits_q  <= '0;
      req_q    <= 1'b0;
      wvalid_q <= 1'b0;
      eop_q    <= 1'b0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acnt_q   <= acnt_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      dst_q    <= dst_d;
      wdata_q  <= wdata_d;
      wbits_q  <= wbits_d;
      req_q    <= req_d;
      wvalid_q <= wvalid_d;
      eop_q    <= eop_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acnt_d   = acnt_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    dst_d    = dst_q;
    wdata_d  = wdata_q;
    wbits_d  = wbits_q;
    wvalid_d = 1'b0;
    eop_d    = 1'b0;
    drop_d   = 1'b0;
    err_d    = 1'b0;
    // Current payload word with the incoming bit merged in at bcnt.
    word         = shift_q;
    word[bcnt_q] = bus.i_data;

    case (state_q)
      IDLE: begin
        shift_d = '0;
        bcnt_d  = '0;
        wcnt_d  = '0;
        if (bus.i_frame) begin
          // Fresh address: clear stale upper bits from the previous packet.
          dst_d    = '0;
          dst_d[0] = bus.i_data;
          acnt_d   = AC_W'(1);
          state_d  = (ADDR_W == 1) ? REQ : ADDR;
        end
      end
      ADDR: begin
        if (!bus.i_frame) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          dst_d[acnt_q] = bus.i_data;
          if (acnt_q == AC_W'(ADDR_W - 1)) state_d = REQ;
          else                             acnt_d  = acnt_q + AC_W'(1);
        end
      end
      REQ: begin
        // Frame fall takes priority over a coincident grant.
        if (!bus.i_frame) begin
          state_d = IDLE;
          err_d   = 1'b1;
          wcnt_d  = '0;
        end else if (bus.i_gnt) begin
          state_d = DATA;
          wcnt_d  = '0;
        end else if (GNT_TIMEOUT != 0) begin
          if (wcnt_q == WC_W'(TO_LAST)) begin
            state_d = DROP;
            drop_d  = 1'b1;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
      end
      DATA: begin
        if (bus.i_frame) begin
          if (bcnt_q == BC_W'(DATA_W - 1)) begin
            wdata_d  = word;
            wbits_d  = WB_W'(DATA_W);
            wvalid_d = 1'b1;
            bcnt_d   = '0;
            shift_d  = '0;
          end else begin
            shift_d = word;
            bcnt_d  = bcnt_q + BC_W'(1);
          end
        end else begin
          // Unfilled upper bits of shift_q are already zero.
          state_d = IDLE;
          eop_d   = 1'b1;
          if (bcnt_q != '0) begin
            wdata_d  = shift_q;
            wbits_d  = WB_W'(bcnt_q);
            wvalid_d = 1'b1;
          end
          bcnt_d  = '0;
          shift_d = '0;
        end
      end
      DROP: begin
        if (!bus.i_frame) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d == REQ) || (state_d == DATA);
  end

  assign bus.o_dst_addr  = dst_q;
  assign bus.o_req       = req_q;
  assign bus.o_wdata     = wdata_q;
  assign bus.o_wvalid    = wvalid_q;
  assign bus.o_wbits     = wbits_q;
  assign bus.o_eop       = eop_q;
  assign bus.o_drop      = drop_q;
  assign bus.o_err       = err_q;
  assign bus.o_state_dbg = state_q;
endmodule

// File: tb/tb_router_iport_param.sv
module tb_router_iport_param;
  localparam int EV_W = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic prev_req;
  logic [EV_W-1:0] act_ev, exp_ev;
  logic [EV_W-1:0] exp_q[$];
  logic [3:0]      exp_req_q[$];
  logic [3:0]      exp_dst;

  router_iport_param_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  router_iport_param #(.ADDR_W(4), .DATA_W(8), .GNT_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EV_W-1:0] ev(input logic err, input logic drop, input logic eop,
                                         input logic wv, input logic [3:0] bits,
                                         input logic [7:0] data);
    return {err, drop, eop, wv, bits, data};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic f, input logic d, input logic g);
    bus.i_frame = f;
    bus.i_data  = d;
    bus.i_gnt   = g;
    @(negedge clk);
  endtask

  task automatic send_addr(input logic [3:0] a);
    exp_req_q.push_back(a);
    for (int i = 0; i < 4; i++) drive(1'b1, a[i], 1'b0);
  endtask

  // n REQ cycles without grant, then one REQ cycle with grant.
  task automatic req_wait(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, v[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},    bus.o_req, 0);
    chk({tag, "_dst"},    bus.o_dst_addr, 0);
    chk({tag, "_wvalid"}, bus.o_wvalid, 0);
    chk({tag, "_wdata"},  bus.o_wdata, 0);
    chk({tag, "_wbits"},  bus.o_wbits, 0);
    chk({tag, "_eop"},    bus.o_eop, 0);
    chk({tag, "_drop"},   bus.o_drop, 0);
    chk({tag, "_err"},    bus.o_err, 0);
    chk({tag, "_state"},  bus.o_state_dbg, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_wvalid || bus.o_eop || bus.o_drop || bus.o_err) begin
        act_ev = ev(bus.o_err, bus.o_drop, bus.o_eop, bus.o_wvalid, bus.o_wbits, bus.o_wdata);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got %0h expected none", act_ev);
        end else begin
          exp_ev = exp_q.pop_front();
          chk("event_flags", {28'd0, act_ev[15:12]}, {28'd0, exp_ev[15:12]});
          if (exp_ev[12]) begin
            chk("wbits", {28'd0, act_ev[11:8]}, {28'd0, exp_ev[11:8]});
            chk("wdata", {24'd0, act_ev[7:0]}, {24'd0, exp_ev[7:0]});
          end
          if (exp_ev[15] || exp_ev[14] || exp_ev[13]) chk("req_low_at_end", bus.o_req, 0);
        end
      end
      if (bus.o_req && !prev_req) begin
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got dst %0h expected no request", bus.o_dst_addr);
        end else begin
          exp_dst = exp_req_q.pop_front();
          chk("dst_addr", bus.o_dst_addr, exp_dst);
        end
      end
    end
    prev_req = bus.o_req;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks    = 0;
    n_fail      = 0;
    prev_req    = 1'b0;
    reset       = 1'b1;
    bus.i_frame = 1'b0;
    bus.i_data  = 1'b0;
    bus.i_gnt   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: addr D, grant after 2 waits, two full words A5, 3C, then eop.
    send_addr(4'hD);
    chk("req_rise_cycle4", bus.o_req, 1);
    req_wait(2);
    exp_q.push_back(ev(0, 0, 0, 1, 4'd8, 8'hA5));
    exp_q.push_back(ev(0, 0, 0, 1, 4'd8, 8'h3C));
    exp_q.push_back(ev(0, 0, 1, 0, 4'd0, 8'h00));
    send_bits(16'h3CA5, 16);
    idle(2);

    // 2: 11 payload bits -> FF (8 bits), 05 (3 bits) with eop.
    send_addr(4'hD);
    req_wait(0);
    exp_q.push_back(ev(0, 0, 0, 1, 4'd8, 8'hFF));
    exp_q.push_back(ev(0, 0, 1, 1, 4'd3, 8'h05));
    send_bits(16'h05FF, 11);
    idle(2);

    // 3: no grant -> drop after 16 REQ cycles, then a normal packet.
    send_addr(4'h2);
    exp_q.push_back(ev(0, 1, 0, 0, 4'd0, 8'h00));
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0);
    chk("req_before_timeout", bus.o_req, 1);
    drive(1'b1, 1'b1, 1'b0);
    chk("req_low_after_drop", bus.o_req, 0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0);
    idle(2);
    send_addr(4'h7);
    req_wait(1);
    exp_q.push_back(ev(0, 0, 0, 1, 4'd8, 8'h81));
    exp_q.push_back(ev(0, 0, 1, 0, 4'd0, 8'h00));
    send_bits(16'h0081, 8);
    idle(2);

    // 4a: frame falls after 2 address bits -> err, no request.
    exp_q.push_back(ev(1, 0, 0, 0, 4'd0, 8'h00));
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    idle(2);
    // 4b: frame falls in REQ with simultaneous grant -> err, no DATA.
    send_addr(4'hB);
    exp_q.push_back(ev(1, 0, 0, 0, 4'd0, 8'h00));
    drive(1'b0, 1'b0, 1'b1);
    chk("state_idle_after_abort", bus.o_state_dbg, 0);
    idle(2);

    // 5: reset mid-DATA after 5 bits, then a clean packet.
    send_addr(4'h6);
    req_wait(0);
    send_bits(16'h0015, 5);
    reset       = 1'b1;
    bus.i_frame = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    send_addr(4'h9);
    req_wait(3);
    exp_q.push_back(ev(0, 0, 0, 1, 4'd8, 8'h5A));
    exp_q.push_back(ev(0, 0, 1, 0, 4'd0, 8'h00));
    send_bits(16'h005A, 8);
    idle(2);

    // 6: grant on first REQ cycle, frame falls right after -> eop only.
    send_addr(4'h4);
    req_wait(0);
    exp_q.push_back(ev(0, 0, 1, 0, 4'd0, 8'h00));
    idle(4);

    chk("events_left", exp_q.size(), 0);
    chk("reqs_left", exp_req_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
